servclone10_wb_arbiter: RTL and testbench
=========================================

SERVCLONE10_WB_ARBITER -- requirements
Module: servclone10_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of wait cycles allowed before a granted transfer is aborted (used only with SERVCLONE10_ARB_TIMEOUT_EN).
REQ-002 wb_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 wb_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_mN_adr  input  32  address from master N, where N = 0 (ibus), 1 (dbus), 2 (aux).
REQ-005 i_mN_dat  input  32  write data from master N.
REQ-006 i_mN_sel  input  4  byte enables from master N.
REQ-007 i_mN_we  input  1  write strobe from master N.
REQ-008 i_mN_cyc  input  1  request from master N; held high until ack.
REQ-009 o_mN_rdt  output  32  read data to master N, valid only with o_mN_ack.
REQ-010 o_mN_ack  output  1  one-cycle completion pulse to master N.
REQ-011 o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc  output  32/32/4/1/1  shared slave (memory) port.
REQ-012 i_s_rdt, i_s_ack  input  32/1  slave read data and acknowledge.
REQ-013 o_grant  output  2  index of the granted master; 3 = none.
REQ-014 o_timeout  output  1  sticky flag: a transfer was aborted.

Function
REQ-015 The arbiter SHALL implement an FSM with two states, IDLE and GRANT.
REQ-016 In IDLE with any i_mN_cyc high, the arbiter SHALL choose a requester round-robin, searching upward from last_grant+1 mod 3, register it as grant and enter GRANT on the next edge.
REQ-017 In IDLE, o_s_cyc SHALL be 0, o_grant SHALL be 3, and all o_mN_ack SHALL be 0.
REQ-018 In GRANT, o_s_adr/dat/sel/we SHALL be combinationally muxed from the granted master, and o_s_cyc SHALL equal that master's i_mN_cyc.
REQ-019 Latency from i_mN_cyc rising (arbiter idle, no contention) to o_s_cyc high SHALL be exactly 1 cycle.
REQ-020 In GRANT, i_s_ack SHALL pass combinationally to o_mN_ack of the granted master only, the FSM SHALL return to IDLE, and last_grant SHALL update to the granted index.
REQ-021 o_mN_rdt SHALL equal i_s_rdt for all N; masters qualify it with ack.
REQ-022 If the granted master drops cyc before ack, the transfer SHALL abort: no ack is issued, the FSM returns to IDLE, and last_grant updates.
REQ-023 The arbiter SHALL insert one idle cycle between consecutive grants, including back-to-back requests from the same master.
REQ-024 An i_s_ack arriving in IDLE SHALL be ignored.
REQ-025 Requests from non-granted masters SHALL remain pending without side effects.

Reset
REQ-026 Asserting wb_rst_n low SHALL immediately force IDLE, last_grant=2, o_grant=3, o_s_cyc=0, all acks 0, o_timeout=0, and the timeout counter to 0.
REQ-027 A reset asserted mid-transfer SHALL drop o_s_cyc with no ack.
REQ-028 After reset, master 0 SHALL have first priority.

Configuration
REQ-029 With SERVCLONE10_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle without ack.
REQ-030 When the counter reaches TIMEOUT, the arbiter SHALL drop o_s_cyc, pulse the granted o_mN_ack for one cycle with o_mN_rdt=0, set o_timeout, and return to IDLE.
REQ-031 Without the macro, GRANT SHALL wait indefinitely for ack, and o_timeout SHALL be tied to 0.

Verification
REQ-032 m0 reads 0x100; slave acks 2 cycles after o_s_cyc with rdt 0x12345678 -> o_s_cyc high 1 cycle after cyc, o_m0_ack pulse with rdt 0x12345678, o_m1_ack=0.
REQ-033 m0, m1 and m2 request in the same cycle after reset -> grants in order 0, 1, 2, with one idle cycle between grants.
REQ-034 m1 writes 0xCAFEF00D with sel 0xF while m0 is waiting -> o_s_dat=0xCAFEF00D, o_s_we=1, and m0 is granted after m1's ack.
REQ-035 m2 drops cyc mid-grant -> no ack, IDLE next cycle, and pending m0 granted on the following cycle.
REQ-036 With the macro defined and TIMEOUT=4, slave never acks m0 -> ack with rdt=0 after 4 GRANT cycles and o_timeout=1 until reset.
REQ-037 wb_rst_n pulsed low during m1's GRANT -> o_s_cyc=0 and o_grant=3 immediately; m0 is granted first after release.

Source files
------------

// File: rtl/servclone10_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// servclone10_wb_arbiter_if
//   Bundle of the three Wishbone master ports, the shared slave port and the
//   arbiter status outputs.
//
//   Master N (0 = ibus, 1 = dbus, 2 = aux):
//     i_mN_adr/dat/sel/we/cyc  request from master N
//     o_mN_rdt/ack             read data and completion pulse to master N
//   Shared slave:
//     o_s_adr/dat/sel/we/cyc   muxed request towards memory
//     i_s_rdt/ack              memory read data and acknowledge
//   Status:
//     o_grant                  index of granted master, 3 = none
//     o_timeout                sticky flag, a transfer was aborted
//
//   modport slave  : the arbiter's view (it serves the masters)
//   modport master : the view of the environment (masters + memory)
// ---------------------------------------------------------------------------
interface servclone10_wb_arbiter_if;
  logic [31:0] i_m0_adr, i_m1_adr, i_m2_adr;
  logic [31:0] i_m0_dat, i_m1_dat, i_m2_dat;
  logic [3:0]  i_m0_sel, i_m1_sel, i_m2_sel;
  logic        i_m0_we,  i_m1_we,  i_m2_we;
  logic        i_m0_cyc, i_m1_cyc, i_m2_cyc;
  logic [31:0] o_m0_rdt, o_m1_rdt, o_m2_rdt;
  logic        o_m0_ack, o_m1_ack, o_m2_ack;

  logic [31:0] o_s_adr;
  logic [31:0] o_s_dat;
  logic [3:0]  o_s_sel;
  logic        o_s_we;
  logic        o_s_cyc;
  logic [31:0] i_s_rdt;
  logic        i_s_ack;

  logic [1:0]  o_grant;
  logic        o_timeout;

  modport slave (
    input  i_m0_adr, i_m1_adr, i_m2_adr,
    input  i_m0_dat, i_m1_dat, i_m2_dat,
    input  i_m0_sel, i_m1_sel, i_m2_sel,
    input  i_m0_we,  i_m1_we,  i_m2_we,
    input  i_m0_cyc, i_m1_cyc, i_m2_cyc,
    output o_m0_rdt, o_m1_rdt, o_m2_rdt,
    output o_m0_ack, o_m1_ack, o_m2_ack,
    output o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
    input  i_s_rdt, i_s_ack,
    output o_grant, o_timeout
  );

  modport master (
    output i_m0_adr, i_m1_adr, i_m2_adr,
    output i_m0_dat, i_m1_dat, i_m2_dat,
    output i_m0_sel, i_m1_sel, i_m2_sel,
    output i_m0_we,  i_m1_we,  i_m2_we,
    output i_m0_cyc, i_m1_cyc, i_m2_cyc,
    input  o_m0_rdt, o_m1_rdt, o_m2_rdt,
    input  o_m0_ack, o_m1_ack, o_m2_ack,
    input  o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
    output i_s_rdt, i_s_ack,
    input  o_grant, o_timeout
  );
endinterface

// File: rtl/servclone10_wb_arbiter.sv
// ---------------------------------------------------------------------------
// servclone10_wb_arbiter
//   Three-master round-robin Wishbone arbiter in front of a single memory
//   port. A two-state FSM (IDLE/GRANT) registers the winner, then muxes that
//   master onto the slave port combinationally and routes the slave ack back
//   to it. Every grant is followed by one IDLE cycle.
//
//   Ports:
//     wb_clk    clock, rising edge
//     wb_rst_n  asynchronous active-low reset
//     bus       servclone10_wb_arbiter_if.slave (master ports, slave port,
//               o_grant, o_timeout)
//
//   Parameter:
//     TIMEOUT   GRANT wait cycles before a transfer is aborted (timeout
//               build only)
//
//   Build option:
//     SERVCLONE10_ARB_TIMEOUT_EN  when defined, a stalled transfer is
//     terminated with a zero-data ack after TIMEOUT cycles and the sticky
//     o_timeout flag is raised. When undefined, GRANT waits forever and
//     o_timeout is tied low.
// ---------------------------------------------------------------------------
module servclone10_wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                           wb_clk,
  input  logic                           wb_rst_n,
  servclone10_wb_arbiter_if.slave        bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [1:0] NONE = 2'd3;

  state_t      state, state_nxt;
  logic [1:0]  grant, grant_nxt;
  logic [1:0]  last_grant, last_grant_nxt;
  logic [2:0]  req;
  logic [2:0]  pick;
  logic        cyc_g;
  logic        ack_g;
  logic        tmo_hit;
  logic [31:0] adr_g, dat_g;
  logic [3:0]  sel_g;
  logic        we_g;

  // Round-robin search starting at last+1 (mod 3). Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    idx = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req  = {bus.i_m2_cyc, bus.i_m1_cyc, bus.i_m0_cyc};
  assign pick = rr_pick(req, last_grant);

  // Signals of the currently granted master.
  always_comb begin
    adr_g = '0;
    dat_g = '0;
    sel_g = '0;
    we_g  = 1'b0;
    cyc_g = 1'b0;
    case (grant)
      2'd0: begin
        adr_g = bus.i_m0_adr; dat_g = bus.i_m0_dat; sel_g = bus.i_m0_sel;
        we_g  = bus.i_m0_we;  cyc_g = bus.i_m0_cyc;
      end
      2'd1: begin
        adr_g = bus.i_m1_adr; dat_g = bus.i_m1_dat; sel_g = bus.i_m1_sel;
        we_g  = bus.i_m1_we;  cyc_g = bus.i_m1_cyc;
      end
      2'd2: begin
        adr_g = bus.i_m2_adr; dat_g = bus.i_m2_dat; sel_g = bus.i_m2_sel;
        we_g  = bus.i_m2_we;  cyc_g = bus.i_m2_cyc;
      end
      default: ;
    endcase
  end

`ifdef SERVCLONE10_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  logic [7:0] tmo_cnt;
  logic       timeout_q;

  // A real ack in the same cycle as the limit wins over the abort.
  assign tmo_hit = (state == GRANT) && cyc_g && !bus.i_s_ack && (tmo_cnt == TMO_LIMIT);

  // Counter runs only while GRANT persists, so it is zero on every entry.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == GRANT) && (state_nxt == GRANT)) tmo_cnt <= tmo_cnt + 8'd1;
      else                                          tmo_cnt <= '0;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  logic [7:0] tmo_unused;
  assign tmo_unused    = 8'(TIMEOUT);
  assign tmo_hit       = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      grant      <= NONE;
      last_grant <= 2'd2;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    ack_g          = 1'b0;
    bus.o_s_adr    = '0;
    bus.o_s_dat    = '0;
    bus.o_s_sel    = '0;
    bus.o_s_we     = 1'b0;
    bus.o_s_cyc    = 1'b0;
    bus.o_grant    = NONE;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nxt = GRANT;
          grant_nxt = pick[1:0];
        end
      end
      GRANT: begin
        bus.o_grant = grant;
        bus.o_s_adr = adr_g;
        bus.o_s_dat = dat_g;
        bus.o_s_sel = sel_g;
        bus.o_s_we  = we_g;
        bus.o_s_cyc = cyc_g && !tmo_hit;
        if (!cyc_g) begin
          // Master gave up: abort silently.
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end else if (bus.i_s_ack || tmo_hit) begin
          ack_g          = 1'b1;
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_m0_ack = ack_g && (grant == 2'd0);
  assign bus.o_m1_ack = ack_g && (grant == 2'd1);
  assign bus.o_m2_ack = ack_g && (grant == 2'd2);

  // Read data is broadcast; a timed-out transfer returns zero.
  assign bus.o_m0_rdt = tmo_hit ? 32'd0 : bus.i_s_rdt;
  assign bus.o_m1_rdt = tmo_hit ? 32'd0 : bus.i_s_rdt;
  assign bus.o_m2_rdt = tmo_hit ? 32'd0 : bus.i_s_rdt;

endmodule

// File: tb/tb_servclone10_wb_arbiter.sv
`timescale 1ns/1ps
module tb_servclone10_wb_arbiter;

  logic wb_clk = 1'b0;
  logic wb_rst_n;
  always #5 wb_clk = ~wb_clk;

  servclone10_wb_arbiter_if bus();

  servclone10_wb_arbiter #(.TIMEOUT(4)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .bus      (bus)
  );

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdt;
    int          dly;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] rdt;
  } sb_t;

  int   total = 0;
  int   bad   = 0;
  sb_t  sbq[$];
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic samp();
    @(negedge wb_clk);
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    case (m)
      0: begin bus.i_m0_cyc = cyc; bus.i_m0_we = we; bus.i_m0_adr = adr; bus.i_m0_dat = dat; bus.i_m0_sel = sel; end
      1: begin bus.i_m1_cyc = cyc; bus.i_m1_we = we; bus.i_m1_adr = adr; bus.i_m1_dat = dat; bus.i_m1_sel = sel; end
      default: begin bus.i_m2_cyc = cyc; bus.i_m2_we = we; bus.i_m2_adr = adr; bus.i_m2_dat = dat; bus.i_m2_sel = sel; end
    endcase
  endtask

  function automatic logic [2:0] acks();
    return {bus.o_m2_ack, bus.o_m1_ack, bus.o_m0_ack};
  endfunction

  function automatic logic [31:0] get_rdt(input int m);
    case (m)
      0:       return bus.o_m0_rdt;
      1:       return bus.o_m1_rdt;
      default: return bus.o_m2_rdt;
    endcase
  endfunction

  // Wait (bounded) for o_s_cyc, then check granted index and the gap length.
  task automatic wait_grant(input int m, input int exp_wait);
    int waited;
    waited = 0;
    while (!bus.o_s_cyc && waited < 20) begin
      step();
      samp();
      waited++;
    end
    chk("grant_seen", {31'd0, bus.o_s_cyc}, 32'd1);
    chk("grant_idx", {30'd0, bus.o_grant}, m);
    chk("grant_wait", waited, exp_wait);
  endtask

  // Drive slave ack this cycle and compare against the scoreboard head.
  task automatic ack_and_check(input logic [31:0] rdt);
    sb_t sc;
    step();
    bus.i_s_ack = 1'b1;
    bus.i_s_rdt = rdt;
    samp();
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      sc = sbq.pop_front();
      chk("ack_onehot", {29'd0, acks()}, 32'd1 << sc.m);
      chk("ack_rdt", get_rdt(sc.m), sc.rdt);
    end
  endtask

  // Release master m and the slave ack, then expect the idle gap.
  task automatic release_m(input int m);
    step();
    drive_m(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    bus.i_s_ack = 1'b0;
    bus.i_s_rdt = 32'd0;
    samp();
    chk("idle_cyc", {31'd0, bus.o_s_cyc}, 32'd0);
    chk("idle_grant", {30'd0, bus.o_grant}, 32'd3);
  endtask

  task automatic do_vec(input vec_t v);
    step();
    drive_m(v.m, 1'b1, v.we, v.adr, v.dat, v.sel);
    samp();
    chk("lat_cyc0", {31'd0, bus.o_s_cyc}, 32'd0);
    step();
    samp();
    chk("lat_cyc1", {31'd0, bus.o_s_cyc}, 32'd1);
    chk("vec_grant", {30'd0, bus.o_grant}, v.m);
    chk("vec_adr", bus.o_s_adr, v.adr);
    chk("vec_dat", bus.o_s_dat, v.dat);
    chk("vec_sel", {28'd0, bus.o_s_sel}, {28'd0, v.sel});
    chk("vec_we", {31'd0, bus.o_s_we}, {31'd0, v.we});
    sbq.push_back('{m: v.m, rdt: v.rdt});
    for (int i = 1; i < v.dly; i++) begin
      chk("no_early_ack", {29'd0, acks()}, 32'd0);
      step();
      samp();
    end
    chk("no_early_ack", {29'd0, acks()}, 32'd0);
    ack_and_check(v.rdt);
    for (int k = 0; k < 3; k++) chk("rdt_bcast", get_rdt(k), v.rdt);
    release_m(v.m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    tbl[0] = '{m: 0, we: 1'b0, adr: 32'h0000_0100, dat: 32'h0,          sel: 4'hF, rdt: 32'h1234_5678, dly: 2};
    tbl[1] = '{m: 1, we: 1'b1, adr: 32'h2000_0004, dat: 32'hA5A5_5A5A, sel: 4'h3, rdt: 32'h0,          dly: 1};
    tbl[2] = '{m: 2, we: 1'b0, adr: 32'h8000_0000, dat: 32'h0,          sel: 4'h1, rdt: 32'hFFFF_0001, dly: 3};
    tbl[3] = '{m: 1, we: 1'b0, adr: 32'hFFFF_FFFC, dat: 32'h1111_2222, sel: 4'hC, rdt: 32'h0BAD_C0DE, dly: 1};

    wb_rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drive_m(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    bus.i_s_ack = 1'b0;
    bus.i_s_rdt = 32'd0;
    repeat (2) samp();
    chk("rst_grant", {30'd0, bus.o_grant}, 32'd3);
    chk("rst_cyc", {31'd0, bus.o_s_cyc}, 32'd0);
    chk("rst_acks", {29'd0, acks()}, 32'd0);
    chk("rst_timeout", {31'd0, bus.o_timeout}, 32'd0);
    step();
    wb_rst_n = 1'b1;
    samp();

    // All three request together: grants 0,1,2 with one idle cycle each.
    step();
    for (int k = 0; k < 3; k++) drive_m(k, 1'b1, 1'b0, 32'h10 * (k + 1), 32'd0, 4'hF);
    samp();
    for (int k = 0; k < 3; k++) begin
      wait_grant(k, 1);
      chk("rr_adr", bus.o_s_adr, 32'h10 * (k + 1));
      sbq.push_back('{m: k, rdt: 32'hA0 + k});
      ack_and_check(32'hA0 + k);
      release_m(k);
    end

    // Ack arriving while idle must be ignored.
    step();
    bus.i_s_ack = 1'b1;
    bus.i_s_rdt = 32'h5555_AAAA;
    samp();
    chk("idle_ack_ign", {29'd0, acks()}, 32'd0);
    chk("idle_ack_cyc", {31'd0, bus.o_s_cyc}, 32'd0);
    step();
    bus.i_s_ack = 1'b0;
    samp();

    for (int i = 0; i < 4; i++) do_vec(tbl[i]);

    // m1 write wins over waiting m0 (last grant = 0), then m0 follows.
    do_vec(tbl[0]);
    step();
    drive_m(0, 1'b1, 1'b0, 32'h40, 32'd0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 4'hF);
    samp();
    wait_grant(1, 1);
    chk("wr_dat", bus.o_s_dat, 32'hCAFE_F00D);
    chk("wr_we", {31'd0, bus.o_s_we}, 32'd1);
    chk("wr_sel", {28'd0, bus.o_s_sel}, 32'hF);
    chk("wr_m0_wait", {31'd0, bus.o_m0_ack}, 32'd0);
    sbq.push_back('{m: 1, rdt: 32'h0});
    ack_and_check(32'h0);
    release_m(1);
    wait_grant(0, 1);
    chk("m0_after_adr", bus.o_s_adr, 32'h40);
    chk("m0_after_we", {31'd0, bus.o_s_we}, 32'd0);
    sbq.push_back('{m: 0, rdt: 32'h7777_0000});
    ack_and_check(32'h7777_0000);
    release_m(0);

    // m2 granted over pending m0, then drops cyc: abort, idle, m0 next.
    step();
    drive_m(2, 1'b1, 1'b0, 32'h200, 32'd0, 4'hF);
    drive_m(0, 1'b1, 1'b0, 32'h300, 32'd0, 4'hF);
    samp();
    wait_grant(2, 1);
    step();
    samp();
    chk("m2_hold", {31'd0, bus.o_s_cyc}, 32'd1);
    step();
    drive_m(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    samp();
    chk("abort_noack", {29'd0, acks()}, 32'd0);
    chk("abort_cyc", {31'd0, bus.o_s_cyc}, 32'd0);
    step();
    samp();
    chk("abort_idle", {30'd0, bus.o_grant}, 32'd3);
    step();
    samp();
    chk("abort_next", {30'd0, bus.o_grant}, 32'd0);
    chk("abort_next_adr", bus.o_s_adr, 32'h300);
    sbq.push_back('{m: 0, rdt: 32'h0000_BEEF});
    ack_and_check(32'h0000_BEEF);
    release_m(0);

`ifdef SERVCLONE10_ARB_TIMEOUT_EN
    // Slave never acks: abort with zero data after 4 GRANT cycles.
    step();
    drive_m(0, 1'b1, 1'b0, 32'h400, 32'd0, 4'hF);
    bus.i_s_rdt = 32'hDEAD_BEEF;
    samp();
    wait_grant(0, 1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      samp();
      if (!bus.o_s_cyc) break;
      cnt++;
    end
    chk("tmo_cycles", cnt, 32'd4);
    chk("tmo_ack", {29'd0, acks()}, 32'd1);
    chk("tmo_rdt", bus.o_m0_rdt, 32'd0);
    chk("tmo_flag_pre", {31'd0, bus.o_timeout}, 32'd0);
    release_m(0);
    chk("tmo_flag", {31'd0, bus.o_timeout}, 32'd1);
    do_vec(tbl[1]);
    chk("tmo_sticky", {31'd0, bus.o_timeout}, 32'd1);
`else
    // Without the timeout, GRANT waits as long as the slave takes.
    step();
    drive_m(0, 1'b1, 1'b0, 32'h400, 32'd0, 4'hF);
    samp();
    wait_grant(0, 1);
    repeat (12) begin
      step();
      samp();
    end
    chk("wait_cyc", {31'd0, bus.o_s_cyc}, 32'd1);
    chk("wait_noack", {29'd0, acks()}, 32'd0);
    chk("no_tmo_flag", {31'd0, bus.o_timeout}, 32'd0);
    sbq.push_back('{m: 0, rdt: 32'h600D_600D});
    ack_and_check(32'h600D_600D);
    release_m(0);
`endif

    // Reset during m1's grant: immediate drop, then m0 wins first.
    do_vec(tbl[0]);
    step();
    drive_m(1, 1'b1, 1'b0, 32'h500, 32'd0, 4'hF);
    samp();
    wait_grant(1, 1);
    step();
    drive_m(0, 1'b1, 1'b0, 32'h600, 32'd0, 4'hF);
    samp();
    chk("pre_rst_grant", {30'd0, bus.o_grant}, 32'd1);
    @(posedge wb_clk);
    #2;
    wb_rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'd0, bus.o_s_cyc}, 32'd0);
    chk("mid_rst_grant", {30'd0, bus.o_grant}, 32'd3);
    chk("mid_rst_acks", {29'd0, acks()}, 32'd0);
    chk("mid_rst_tmo", {31'd0, bus.o_timeout}, 32'd0);
    samp();
    step();
    wb_rst_n = 1'b1;
    samp();
    chk("post_rst_idle", {30'd0, bus.o_grant}, 32'd3);
    wait_grant(0, 1);
    chk("post_rst_adr", bus.o_s_adr, 32'h600);
    sbq.push_back('{m: 0, rdt: 32'h0000_0600});
    ack_and_check(32'h0000_0600);
    release_m(0);
    step();
    drive_m(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    samp();
    chk("sb_drained", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
